seg_scan_ctrl: RTL
==================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the 8-digit 7-segment display. Takes the
//  packed display word (8 nibbles) and decimal-point list from the measurement/
//  state controller, sequences one digit per scan slot, and drives segments and
//  anodes. Adds frame-synchronous latching, digit blanking and per-digit blinking.
// PARAMETERS
//  CLK_DIV        50000  clk cycles per digit slot (>=2)
//  BLINK_DIV      32     frames per blink half-period (>=1)
//  SEG_ACT_LOW    1      1: seg outputs active-low, 0: active-high
//  AN_ACT_LOW     1      1: anode outputs active-low, 0: active-high
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous, active-high reset
//  en          in   1   display enable
//  number      in   32  digit i = number[4i+3:4i], digit 0 rightmost
//  dp_list     in   8   dp_list[i] lights decimal point of digit i
//  blink_mask  in   8   blink_mask[i]=1: digit i blinks
//  seg         out  8   seg[7]=dp, seg[6:0]=g..a
//  an          out  8   an[i] selects digit i (one-hot when active)
//  digit_idx   out  3   digit currently being driven
//  frame_done  out  1   1-cycle pulse at each frame wrap
// BEHAVIOUR
//  - Reset (async): div_cnt=0, digit_idx=0, blink_phase=0, shadows=0,
//    frame_done=0, seg and an all inactive (8'hFF when ACT_LOW=1).
//  - div_cnt counts 0..CLK_DIV-1; tick when div_cnt==CLK_DIV-1.
//  - On tick digit_idx increments, 7 wraps to 0. On the 7->0 tick (frame wrap):
//    shadow_number/dp/blink <= number/dp_list/blink_mask; frame_done=1 next cycle.
//  - Inputs only take effect at frame wrap; mid-frame changes never tear a frame.
//  - blink_phase toggles after every BLINK_DIV frame wraps (frame counter wraps).
//  - seg/an registered: reflect digit_idx with 1-cycle latency.
//  - Decode (active-high gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
//    8:7F 9:6F A:40('-') B..F: 00 (blank). seg[7]=shadow_dp[idx], honoured on blank.
//  - Blink: blink_phase=1 and shadow_blink[idx]=1 -> seg fully inactive incl dp;
//    an still driven.
//  - Polarity: SEG_ACT_LOW/AN_ACT_LOW invert final registered values only.
//  - en=0: div_cnt, digit_idx, blink counter/phase held at 0; shadows load every
//    cycle; seg, an inactive; frame_done=0. First slot after en rises is digit 0
//    with shadows captured on the last en=0 cycle.
//  - en and tick same cycle: en=0 wins. rst mid-frame: outputs inactive at once.
// TESTING (sim with CLK_DIV=4, BLINK_DIV=2, ACT_LOW=1)
//  1 rst=1 mid-scan -> seg=8'hFF, an=8'hFF same cycle; after release digit_idx=0.
//  2 en=1, number=32'h08080706, dp_list=8'b0001_0000 -> slot0: an=8'hFE, seg=8'h82;
//    slot4: an=8'hEF, seg=8'h00 ('8' with dp); slot1 seg=8'hC0.
//  3 change number to 32'hff020202 mid-frame -> old value until frame_done, new
//    value from next slot0; frame_done high exactly 1 cycle per 32 clocks.
//  4 number=32'hffffff02, dp_list=8'h01 -> slot0 seg=8'h24, slot1 seg=8'hC0,
//    slots 2..7 seg=8'hFF with an one-hot still cycling.
//  5 blink_mask=8'h01 -> slot0 seg alternates 2 frames shown / 2 frames 8'hFF;
//    other digits steady.
//  6 en=0 mid-frame -> next cycle seg=an=8'hFF, digit_idx=0; en=1 -> slot0 first.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed 7-segment display. It latches the
// display inputs once per frame, drives one digit per slot and handles blanking and blinking.
module seg_digit_dec (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h40;
      default: seg = 7'h00;
    endcase
  end
endmodule

module seg_scan_ctrl #(
  parameter int CLK_DIV     = 50000,
  parameter int BLINK_DIV   = 32,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] number,
  input  logic [7:0]  dp_list,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);
  localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] AN_OFF  = AN_ACT_LOW  ? 8'hFF : 8'h00;

  logic [DIV_W-1:0] div_cnt;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;
  logic [31:0]      shadow_number;
  logic [7:0]       shadow_dp, shadow_blink;
  logic [7:0][6:0]  dec_seg;
  logic [7:0]       seg_raw, an_raw;
  logic             tick, wrap;

  // one decoder per digit position, selected by digit_idx below
  for (genvar i = 0; i < 8; i++) begin : g_dec
    seg_digit_dec u_dec (.nib(shadow_number[4*i +: 4]), .seg(dec_seg[i]));
  end

  assign tick = (div_cnt == DIV_MAX);
  assign wrap = tick && (digit_idx == 3'd7);

  always_comb begin
    seg_raw = {shadow_dp[digit_idx], dec_seg[digit_idx]};
    if (blink_phase && shadow_blink[digit_idx]) seg_raw = 8'h00;
    an_raw = 8'b1 << digit_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt       <= '0;
      digit_idx     <= '0;
      blink_cnt     <= '0;
      blink_phase   <= 1'b0;
      shadow_number <= '0;
      shadow_dp     <= '0;
      shadow_blink  <= '0;
      frame_done    <= 1'b0;
      seg           <= SEG_OFF;
      an            <= AN_OFF;
    end else if (!en) begin
      // shadows track inputs so the first frame after enable shows fresh data
      div_cnt       <= '0;
      digit_idx     <= '0;
      blink_cnt     <= '0;
      blink_phase   <= 1'b0;
      shadow_number <= number;
      shadow_dp     <= dp_list;
      shadow_blink  <= blink_mask;
      frame_done    <= 1'b0;
      seg           <= SEG_OFF;
      an            <= AN_OFF;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      frame_done <= wrap;
      if (tick) digit_idx <= digit_idx + 1'b1;
      if (wrap) begin
        shadow_number <= number;
        shadow_dp     <= dp_list;
        shadow_blink  <= blink_mask;
        if (blink_cnt == BLK_MAX) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      seg <= SEG_ACT_LOW ? ~seg_raw : seg_raw;
      an  <= AN_ACT_LOW  ? ~an_raw  : an_raw;
    end
  end
endmodule
